add_int8_serial: RTL and testbench



---
 rtl/add_int8_serial_pkg.sv | 13 +
 rtl/full_adder_1bit.sv | 33 +++
 rtl/add_int8_serial.sv | 96 +++++++++
 tb/tb_add_int8_serial.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/add_int8_serial_pkg.sv
// rtl/add_int8_serial_pkg.sv - shared state and cell-style encodings for the bit-serial adder
package add_int8_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int IMPL_XOR  = 0;
  localparam int IMPL_NAND = 1;

endpackage

// File: rtl/full_adder_1bit.sv
// rtl/full_adder_1bit.sv - single-bit full adder cell, XOR/majority or NAND-only form
module full_adder_1bit
  import add_int8_serial_pkg::*;
#(
  parameter int IMPL_TYPE = IMPL_XOR
) (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  generate
    if (IMPL_TYPE == IMPL_NAND) begin : g_nand
      logic n1, n2, n3, x1, n4, n5, n6;
      // Classic nine-gate NAND full adder; n1 and n4 double as the carry terms.
      assign n1   = ~(a & b);
      assign n2   = ~(a & n1);
      assign n3   = ~(b & n1);
      assign x1   = ~(n2 & n3);
      assign n4   = ~(x1 & cin);
      assign n5   = ~(x1 & n4);
      assign n6   = ~(cin & n4);
      assign s    = ~(n5 & n6);
      assign cout = ~(n1 & n4);
    end else begin : g_xor
      assign s    = a ^ b ^ cin;
      assign cout = (a & b) | (a & cin) | (b & cin);
    end
  endgenerate

endmodule

// File: rtl/add_int8_serial.sv
// rtl/add_int8_serial.sv - LSB-first bit-serial adder with valid/ready handshakes
module add_int8_serial
  import add_int8_serial_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int IMPL_TYPE = IMPL_XOR
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sr, b_sr, sum_r;
  logic             cout_r, ovf_r;
  logic             fa_s, fa_c;
  logic             last_bit;

  // One cell, reused for every bit position over WIDTH cycles.
  full_adder_1bit #(.IMPL_TYPE(IMPL_TYPE)) u_fa (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .cin (carry),
    .s   (fa_s),
    .cout(fa_c)
  );

  assign last_bit  = (cnt == CNT_LAST);
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign Sum       = sum_r;
  assign Cout      = cout_r;
  assign Ovf       = ovf_r;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid)  state_nxt = ST_RUN;
      ST_RUN:  if (last_bit)  state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_sr  <= A;
            b_sr  <= B;
            carry <= 1'b0;
            cnt   <= '0;
          end
        end
        ST_RUN: begin
          carry <= fa_c;
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          sum_r <= {fa_s, sum_r[WIDTH-1:1]};
          cnt   <= cnt + CW'(1);
          // Overflow is carry-into-MSB xor carry-out-of-MSB.
          if (last_bit) begin
            cout_r <= fa_c;
            ovf_r  <= fa_c ^ carry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_add_int8_serial.sv
// tb/tb_add_int8_serial.sv - randomized self-checking bench for add_int8_serial, both cell styles
module tb_add_int8_serial;
  import add_int8_serial_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] a_in = 8'd0;
  logic [7:0] b_in = 8'd0;
  logic [1:0] in_rdy, o_vld, o_cout, o_ovf;
  logic [7:0] o_sum [2];

  int n_pass = 0;
  int n_total = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  add_int8_serial #(.WIDTH(8), .IMPL_TYPE(IMPL_XOR)) u_xor (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[0]),
    .A(a_in), .B(b_in), .out_valid(o_vld[0]), .out_ready(out_ready),
    .Sum(o_sum[0]), .Cout(o_cout[0]), .Ovf(o_ovf[0])
  );

  add_int8_serial #(.WIDTH(8), .IMPL_TYPE(IMPL_NAND)) u_nand (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[1]),
    .A(a_in), .B(b_in), .out_valid(o_vld[1]), .out_ready(out_ready),
    .Sum(o_sum[1]), .Cout(o_cout[1]), .Ovf(o_ovf[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Transaction-level reference: a countdown from the accept edge, results from plain arithmetic.
  logic       m_valid = 1'b0;
  int         m_left = 0;
  logic [7:0] m_sum = 8'd0, p_sum = 8'd0;
  logic       m_cout = 1'b0, m_ovf = 1'b0, p_cout = 1'b0, p_ovf = 1'b0;
  logic       m_idle;
  assign m_idle = !m_valid && (m_left == 0);

  always @(posedge clk) begin
    int ssum;
    if (!rst_n) begin
      m_valid = 1'b0; m_left = 0;
      m_sum = 8'd0; m_cout = 1'b0; m_ovf = 1'b0;
    end else if (m_valid) begin
      if (out_ready) m_valid = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_valid = 1'b1; m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf;
      end
    end else if (in_valid) begin
      p_sum  = 8'((int'(a_in) + int'(b_in)) % 256);
      p_cout = (int'(a_in) + int'(b_in)) > 255;
      ssum   = int'($signed(a_in)) + int'($signed(b_in));
      p_ovf  = (ssum > 127) || (ssum < -128);
      m_left = 8;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("in_ready[%0d]", d), in_rdy[d], m_idle);
        chk($sformatf("out_valid[%0d]", d), o_vld[d], m_valid);
        if (m_idle || m_valid) begin
          chk($sformatf("sum[%0d]", d), o_sum[d], m_sum);
          chk($sformatf("cout[%0d]", d), o_cout[d], m_cout);
          chk($sformatf("ovf[%0d]", d), o_ovf[d], m_ovf);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] s, output logic c, output logic o, output int lat);
    int w;
    s = 8'd0; c = 1'b0; o = 1'b0; lat = 0;
    a_in = a; b_in = b; in_valid = 1'b1;
    w = 0;
    while (!in_rdy[0] && w < 40) begin tick(); w++; end
    if (!in_rdy[0]) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    tick();
    in_valid = 1'b0;
    a_in = 8'($urandom); b_in = 8'($urandom);
    out_ready = 1'($urandom_range(0, 1));
    while (!o_vld[0] && lat < 20) begin tick(); lat++; end
    s = o_sum[0]; c = o_cout[0]; o = o_ovf[0];
    out_ready = 1'b0;
    repeat ($urandom_range(0, 2)) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  logic [7:0] ta [3] = '{8'hFF, 8'h7F, 8'h80};
  logic [7:0] tb [3] = '{8'h01, 8'h01, 8'h80};
  logic [7:0] ts [3] = '{8'h00, 8'h80, 8'h00};
  logic       tc [3] = '{1'b1, 1'b0, 1'b1};
  logic       tv [3] = '{1'b0, 1'b1, 1'b1};

  initial begin
    logic [7:0] s, ra, rb;
    logic       c, o;
    int         lat;

    rst_n = 1'b0;
    tick();
    started = 1'b1;
    tick();
    rst_n = 1'b1;
    chk("rst_in_ready", in_rdy[0], 1'b1);
    chk("rst_out_valid", o_vld[0], 1'b0);
    chk("rst_sum", o_sum[0], 8'd0);
    chk("rst_cout", o_cout[0], 1'b0);
    chk("rst_ovf", o_ovf[0], 1'b0);

    run_op(8'd100, 8'd27, s, c, o, lat);
    chk("t1_sum", s, 8'd127);
    chk("t1_cout", c, 1'b0);
    chk("t1_ovf", o, 1'b0);
    chk("t1_latency", lat, 8);

    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb[i], s, c, o, lat);
      chk($sformatf("t2_sum_%0d", i), s, ts[i]);
      chk($sformatf("t2_cout_%0d", i), c, tc[i]);
      chk($sformatf("t2_ovf_%0d", i), o, tv[i]);
    end

    // Backpressure with new operands waiting on in_valid.
    a_in = 8'd1; b_in = 8'd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    chk("t3_valid", o_vld[0], 1'b1);
    chk("t3_sum", o_sum[0], 8'd3);
    a_in = 8'd9; b_in = 8'd10; in_valid = 1'b1; out_ready = 1'b0;
    repeat (5) begin
      tick();
      chk("t3_hold_sum", o_sum[0], 8'd3);
      chk("t3_hold_in_ready", in_rdy[0], 1'b0);
      chk("t3_hold_valid", o_vld[0], 1'b1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t3_release_in_ready", in_rdy[0], 1'b1);
    chk("t3_release_valid", o_vld[0], 1'b0);
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    chk("t3_second_valid", o_vld[0], 1'b1);
    chk("t3_second_sum", o_sum[0], 8'd19);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset during the third RUN cycle.
    a_in = 8'h55; b_in = 8'h33; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t4_in_ready", in_rdy[0], 1'b1);
    chk("t4_out_valid", o_vld[0], 1'b0);
    chk("t4_sum", o_sum[0], 8'd0);
    chk("t4_cout", o_cout[0], 1'b0);
    run_op(8'h01, 8'h02, s, c, o, lat);
    chk("t4_fresh_sum", s, 8'h03);
    chk("t4_fresh_latency", lat, 8);

    // Round trip through the subtraction inverse.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_op(ra - rb, rb, s, c, o, lat);
      chk("t5_roundtrip", s, ra);
      chk("t5_latency", lat, 8);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
